nibble_packer: RTL and testbench

NIBBLE_PACKER -- requirements
Module: nibble_packer

---
 rtl/nibble_pkg.sv | 16 +
 rtl/nibble_fifo.sv | 72 +++++++
 rtl/nibble_packer.sv | 151 +++++++++++++++
 tb/tb_nibble_packer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_pkg.sv
// nibble_pkg: shared types and widths for the nibble packer slice.
//   NIBBLE_W - width of one captured nibble
//   BYTE_W   - width of one packed output byte
//   state_t  - packer FSM states (WARMUP, LO, HI)
package nibble_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned BYTE_W   = 8;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    LO     = 2'd1,
    HI     = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_fifo.sv
// nibble_fifo: small synchronous FIFO with a combinational read port.
//   clk, rst       - clock, synchronous active-high reset
//   push, wdata    - write request and data (ignored when full without a pop)
//   pop            - read request (ignored when empty)
//   rdata          - head entry, read straight from storage
//   full, empty    - registered occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module nibble_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nx;
  logic             do_push_c;
  logic             do_pop_c;

  // Qualify requests; a push into a full FIFO is allowed only alongside a pop.
  always_comb begin
    do_pop_c  = pop & ~empty;
    do_push_c = push & (~full | do_pop_c);
    count_nx  = count;
    if (do_push_c && !do_pop_c) begin
      count_nx = count + CW'(1);
    end else if (do_pop_c && !do_push_c) begin
      count_nx = count - CW'(1);
    end
  end

  // Storage, pointers and registered flags; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push_c) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_nx;
      full  <= (count_nx == CW'(DEPTH));
      empty <= (count_nx == '0);
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/nibble_packer.sv
// nibble_packer: samples a 4-bit upstream shift register once per NIBBLE_PERIOD
// cycles and packs pairs of nibbles into bytes {high, low} queued in a FIFO.
//   clk, rst    - clock, synchronous active-high reset
//   x_in        - parallel view of the upstream shift register
//   out_data    - head byte of the FIFO (valid when out_valid)
//   out_valid   - FIFO non-empty
//   out_ready   - consumer accepts the head byte
//   overflow    - sticky: a byte was dropped on a full FIFO
//   byte_count  - bytes accepted into the FIFO, wraps at 256
//   out_parity  - even parity of out_data (only with NIBBLE_PACKER_PARITY_EN)
// Build option: define NIBBLE_PACKER_PARITY_EN to add per-entry parity.
module nibble_packer
  import nibble_pkg::*;
#(
  parameter int unsigned NIBBLE_PERIOD = 4,
  parameter int unsigned FIFO_DEPTH    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NIBBLE_W-1:0] x_in,
  output logic [BYTE_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overflow,
  output logic [BYTE_W-1:0]   byte_count
`ifdef NIBBLE_PACKER_PARITY_EN
  ,
  output logic                out_parity
`endif
);

  localparam int unsigned PHASE_W = (NIBBLE_PERIOD > 1) ? $clog2(NIBBLE_PERIOD) : 1;
`ifdef NIBBLE_PACKER_PARITY_EN
  localparam int unsigned FIFO_W = BYTE_W + 1;
`else
  localparam int unsigned FIFO_W = BYTE_W;
`endif

  state_t              state;
  state_t              state_nx;
  logic [PHASE_W-1:0]  phase;
  logic [NIBBLE_W-1:0] lo;
  logic                strobe_c;
  logic                lo_load_c;
  logic                push_c;
  logic                pop_c;
  logic                accept_c;
  logic                drop_c;
  logic [BYTE_W-1:0]   byte_c;
  logic [FIFO_W-1:0]   fifo_wdata;
  logic [FIFO_W-1:0]   fifo_rdata;
  logic                fifo_full;
  logic                fifo_empty;

  assign strobe_c = (phase == PHASE_W'(NIBBLE_PERIOD - 1));

  // Phase counter: one capture strobe per NIBBLE_PERIOD cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
    end else if (strobe_c) begin
      phase <= '0;
    end else begin
      phase <= phase + PHASE_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WARMUP;
    end else begin
      state <= state_nx;
    end
  end

  // Next state; the first strobe after reset only marks the shift register as filled.
  always_comb begin
    state_nx  = state;
    lo_load_c = 1'b0;
    push_c    = 1'b0;
    if (strobe_c) begin
      case (state)
        WARMUP: state_nx = LO;
        LO: begin
          state_nx  = HI;
          lo_load_c = 1'b1;
        end
        HI: begin
          state_nx = LO;
          push_c   = 1'b1;
        end
        default: state_nx = WARMUP;
      endcase
    end
  end

  // Low-nibble holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      lo <= '0;
    end else if (lo_load_c) begin
      lo <= x_in;
    end
  end

  assign byte_c   = {x_in, lo};
  assign pop_c    = out_valid & out_ready;
  assign accept_c = push_c & (~fifo_full | pop_c);
  assign drop_c   = push_c & fifo_full & ~pop_c;

  // Accepted-byte counter and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (accept_c) begin
        byte_count <= byte_count + BYTE_W'(1);
      end
      if (drop_c) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef NIBBLE_PACKER_PARITY_EN
  assign fifo_wdata = {^byte_c, byte_c};
  assign out_parity = fifo_rdata[BYTE_W];
`else
  assign fifo_wdata = byte_c;
`endif

  nibble_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .wdata (fifo_wdata),
    .pop   (pop_c),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_data  = fifo_rdata[BYTE_W-1:0];
  assign out_valid = ~fifo_empty;

endmodule

// File: tb/tb_nibble_packer.sv
// tb_nibble_packer: table-driven and hand-sequenced checks of nibble_packer
// with a scoreboard queue of expected bytes compared at each handshake.
module tb_nibble_packer;
  import nibble_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] x_in = 4'h0;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       overflow;
  logic [7:0] byte_count;
`ifdef NIBBLE_PACKER_PARITY_EN
  logic       out_parity;
`endif

  nibble_packer #(
    .NIBBLE_PERIOD (4),
    .FIFO_DEPTH    (2)
  ) dut (
`ifdef NIBBLE_PACKER_PARITY_EN
    .out_parity (out_parity),
`endif
    .clk        (clk),
    .rst        (rst),
    .x_in       (x_in),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overflow   (overflow),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] lo;
    logic [3:0] hi;
    logic [7:0] exp;
  } vec_t;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  int         acc_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every handshake must match the oldest expected byte.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      logic [7:0] e;
      vectors++;
      acc_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_byte: got %h, none expected (t=%0t)", out_data, $time);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e) begin
          miscompares++;
          $display("FAIL byte_out: got %h, want %h (t=%0t)", out_data, e, $time);
        end
`ifdef NIBBLE_PACKER_PARITY_EN
        vectors++;
        if (out_parity !== ^e) begin
          miscompares++;
          $display("FAIL parity: got %b, want %b for %h", out_parity, ^e, e);
        end
`endif
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic slot(input logic [3:0] v);
    x_in = v;
    repeat (4) tick();
  endtask

  task automatic send_byte(input logic [3:0] lo, input logic [3:0] hi);
    slot(lo);
    slot(hi);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t       tbl[8];
    logic [3:0] sr;
    logic       d;

    tbl[0] = '{4'h0, 4'h0, 8'h00};
    tbl[1] = '{4'hA, 4'h5, 8'h5A};
    tbl[2] = '{4'hB, 4'h5, 8'h5B};
    tbl[3] = '{4'hF, 4'hF, 8'hFF};
    tbl[4] = '{4'h1, 4'hE, 8'hE1};
    tbl[5] = '{4'hC, 4'h3, 8'h3C};
    tbl[6] = '{4'h7, 4'h8, 8'h87};
    tbl[7] = '{4'h5, 4'hA, 8'hA5};

    // Reset state and first byte with latency.
    out_ready = 1'b1;
    do_reset(2);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_count", 32'(byte_count), 32'd0);
    slot(4'h0);
    slot(4'hA);
    x_in = 4'h5;
    repeat (3) tick();
    chk("latency_early", 32'(out_valid), 32'd0);
    exp_q.push_back(8'h5A);
    tick();
    chk("latency_valid", 32'(out_valid), 32'd1);
    chk("first_data", 32'(out_data), 32'h5A);
    tick();
    chk("valid_one_cycle", 32'(out_valid), 32'd0);
    chk("first_count", 32'(byte_count), 32'd1);

    // Serial stream through a bench shift register: windows alternate 3 / C.
    do_reset(1);
    acc_cyc.delete();
    sr = 4'h0;
    repeat (6) exp_q.push_back(8'h3C);
    for (int k = 0; k < 52; k++) begin
      d = (((k + 2) / 4) % 2) == 1;
      sr = {sr[2:0], d};
      x_in = sr;
      tick();
    end
    tick();
    chk("stream_bytes", 32'(acc_cyc.size()), 32'd6);
    for (int i = 0; i + 1 < acc_cyc.size(); i++) begin
      chk("stream_interval", 32'(acc_cyc[i+1] - acc_cyc[i]), 32'd8);
    end
    chk("stream_count", 32'(byte_count), 32'd6);

    // Backpressure for three byte periods on a two-entry FIFO.
    out_ready = 1'b0;
    do_reset(1);
    slot(4'h0);
    send_byte(4'h1, 4'h9);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_data1", 32'(out_data), 32'h91);
    send_byte(4'h2, 4'h6);
    chk("bp_data2", 32'(out_data), 32'h91);
    chk("bp_no_ovf", 32'(overflow), 32'd0);
    send_byte(4'h3, 4'hC);
    chk("bp_data3", 32'(out_data), 32'h91);
    chk("bp_overflow", 32'(overflow), 32'd1);
    chk("bp_count", 32'(byte_count), 32'd2);
    exp_q.push_back(8'h91);
    exp_q.push_back(8'h62);
    out_ready = 1'b1;
    tick();
    chk("bp_head2", 32'(out_data), 32'h62);
    tick();
    chk("bp_drained", 32'(out_valid), 32'd0);
    chk("bp_sticky", 32'(overflow), 32'd1);

    // Full FIFO with the pop landing on the HI strobe cycle.
    out_ready = 1'b0;
    do_reset(1);
    chk("ovf_reset_clear", 32'(overflow), 32'd0);
    slot(4'h0);
    send_byte(4'h4, 4'h8);
    send_byte(4'h5, 4'h7);
    slot(4'h6);
    x_in = 4'hB;
    repeat (3) tick();
    exp_q.push_back(8'h84);
    exp_q.push_back(8'h75);
    exp_q.push_back(8'hB6);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("full_pp_ovf", 32'(overflow), 32'd0);
    chk("full_pp_head", 32'(out_data), 32'h75);
    chk("full_pp_count", 32'(byte_count), 32'd3);
    out_ready = 1'b1;
    tick();
    chk("full_pp_occ2", 32'(out_valid), 32'd1);
    chk("full_pp_tail", 32'(out_data), 32'hB6);
    tick();
    chk("full_pp_empty", 32'(out_valid), 32'd0);

    // Reset while in HI: the latched low nibble must never surface.
    out_ready = 1'b1;
    do_reset(1);
    slot(4'h0);
    slot(4'h7);
    x_in = 4'hE;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_hi_valid", 32'(out_valid), 32'd0);
    chk("rst_hi_count", 32'(byte_count), 32'd0);
    slot(4'h0);
    slot(4'h1);
    x_in = 4'h2;
    repeat (3) tick();
    chk("rst_hi_no_early", 32'(out_valid), 32'd0);
    exp_q.push_back(8'h21);
    tick();
    chk("rst_hi_valid2", 32'(out_valid), 32'd1);
    chk("rst_hi_data", 32'(out_data), 32'h21);
    tick();
    chk("rst_hi_drained", 32'(out_valid), 32'd0);

    // Table-driven run of 256 bytes: byte_count wraps to 0.
    do_reset(1);
    slot(4'h0);
    for (int n = 0; n < 256; n++) begin
      send_byte(tbl[n % 8].lo, tbl[n % 8].hi);
      exp_q.push_back(tbl[n % 8].exp);
      if (n == 7) chk("tbl_count8", 32'(byte_count), 32'd8);
      if (n == 254) chk("tbl_count255", 32'(byte_count), 32'd255);
    end
    chk("tbl_count_wrap", 32'(byte_count), 32'd0);
    tick();
    chk("tbl_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("tbl_no_ovf", 32'(overflow), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
